// File: rtl/dmem_ctrl.sv
// Data-memory responder: turns MEM-stage word requests into byte accesses on a byte-wide RAM.
// Optional one-word read buffer enabled by defining DMEM_CTRL_RBUF_EN.
module dmem_ctrl #(
  parameter int ADDR_W = 17,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_r_enable_i,
  input  logic              mem_w_enable_i,
  input  logic [3:0]        mem_w_mask_i,
  input  logic [31:0]       mem_w_data_i,
  input  logic [31:0]       mem_addr_i,
  output logic [31:0]       mem_r_data_o,
  output logic              mem_busy_o,
  output logic              mem_done_o,
  output logic              ram_en_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [7:0]        ram_wdata_o,
  input  logic [7:0]        ram_rdata_i
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t              state_q;
  logic [ADDR_W-3:0]   addr_q;
  logic [3:0]          mask_q;
  logic [31:0]         wdata_q;
  logic [31:0]         word_q;
  logic [2:0]          cyc_q;
  logic [31:0]         rdata_q;
  logic                busy_q;
  logic                done_q;
  logic                en_q;
  logic                we_q;
  logic [ADDR_W-1:0]   raddr_q;
  logic [7:0]          wbyte_q;

  logic [ADDR_W-3:0]   req_tag;
  logic [1:0]          acc_lane;
  logic [1:0]          nxt_lane;
  logic [2:0]          cap_lane;
  logic                cap_vld;
  logic                rbuf_hit;
  logic                unused_addr;

  function automatic logic [1:0] low_lane(input logic [3:0] m);
    if (m[0])      return 2'd0;
    else if (m[1]) return 2'd1;
    else if (m[2]) return 2'd2;
    else           return 2'd3;
  endfunction

  assign req_tag     = mem_addr_i[ADDR_W-1:2];
  assign acc_lane    = low_lane(mem_w_mask_i);
  assign nxt_lane    = low_lane(mask_q);
  // Lane k's byte is due RD_LAT-1 cycles after it is issued; cyc_q counts RD cycles from 1.
  assign cap_lane    = cyc_q - 3'(RD_LAT);
  assign cap_vld     = (cyc_q >= 3'(RD_LAT));
  assign unused_addr = ^{mem_addr_i[31:ADDR_W], mem_addr_i[1:0]};

`ifdef DMEM_CTRL_RBUF_EN
  // The buffered word always equals rdata_q: both are loaded together and writes touch neither.
  logic              rbuf_vld_q;
  logic [ADDR_W-3:0] rbuf_tag_q;
  assign rbuf_hit = rbuf_vld_q && (rbuf_tag_q == req_tag);
`else
  assign rbuf_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
      wdata_q <= '0;
      word_q  <= '0;
      cyc_q   <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      raddr_q <= '0;
      wbyte_q <= '0;
`ifdef DMEM_CTRL_RBUF_EN
      rbuf_vld_q <= 1'b0;
      rbuf_tag_q <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (mem_w_enable_i) begin
            addr_q  <= req_tag;
            wdata_q <= mem_w_data_i;
`ifdef DMEM_CTRL_RBUF_EN
            if (rbuf_tag_q == req_tag) rbuf_vld_q <= 1'b0;
`endif
            if (mem_w_mask_i == 4'b0000) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= WR;
              busy_q  <= 1'b1;
              en_q    <= 1'b1;
              we_q    <= 1'b1;
              raddr_q <= {req_tag, acc_lane};
              wbyte_q <= mem_w_data_i[{acc_lane, 3'b000} +: 8];
              mask_q  <= mem_w_mask_i & ~(4'b0001 << acc_lane);
            end
          end else if (mem_r_enable_i) begin
            addr_q <= req_tag;
            if (rbuf_hit) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= RD;
              busy_q  <= 1'b1;
              en_q    <= 1'b1;
              we_q    <= 1'b0;
              raddr_q <= {req_tag, 2'd0};
              cyc_q   <= 3'd1;
            end
          end
        end

        RD: begin
          cyc_q <= cyc_q + 3'd1;
          if (cyc_q < 3'd4) begin
            en_q    <= 1'b1;
            raddr_q <= {addr_q, cyc_q[1:0]};
          end else begin
            en_q <= 1'b0;
          end
          if (cap_vld) begin
            word_q[{cap_lane[1:0], 3'b000} +: 8] <= ram_rdata_i;
            if (cap_lane == 3'd3) begin
              rdata_q <= {ram_rdata_i, word_q[23:0]};
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              en_q    <= 1'b0;
`ifdef DMEM_CTRL_RBUF_EN
              rbuf_vld_q <= 1'b1;
              rbuf_tag_q <= addr_q;
`endif
            end
          end
        end

        WR: begin
          if (mask_q == 4'b0000) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
          end else begin
            raddr_q <= {addr_q, nxt_lane};
            wbyte_q <= wdata_q[{nxt_lane, 3'b000} +: 8];
            mask_q  <= mask_q & ~(4'b0001 << nxt_lane);
          end
        end

        default: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_r_data_o = rdata_q;
  assign mem_busy_o   = busy_q;
  assign mem_done_o   = done_q;
  assign ram_en_o     = en_q;
  assign ram_we_o     = we_q;
  assign ram_addr_o   = raddr_q;
  assign ram_wdata_o  = wbyte_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl with a byte RAM model (read data valid in the strobe cycle, RD_LAT = 1).
module tb_dmem_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        r_en, w_en;
  logic [3:0]  w_mask;
  logic [31:0] w_data, addr;
  logic [31:0] r_data;
  logic        busy, done, ram_en, ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata, ram_rdata;

  int checks = 0;
  int failures = 0;

  logic [7:0]  ram [0:4095];
  logic        pl_en = 1'b0;
  logic [11:0] pl_addr = '0;
  logic [7:0]  pl_data = '0;

  always #5 clk = ~clk;

  dmem_ctrl #(.ADDR_W(17), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .mem_r_enable_i(r_en), .mem_w_enable_i(w_en), .mem_w_mask_i(w_mask),
    .mem_w_data_i(w_data), .mem_addr_i(addr), .mem_r_data_o(r_data),
    .mem_busy_o(busy), .mem_done_o(done),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ram_en && ram_we) ram[ram_addr[11:0]] <= ram_wdata;
  end
  assign ram_rdata = ram[ram_addr[11:0]];

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  // Presents a request in cycle 0; returns just after the accepting edge.
  task automatic issue(input logic r, input logic w, input logic [3:0] m,
                       input logic [31:0] d, input logic [31:0] a);
    @(negedge clk);
    r_en = r; w_en = w; w_mask = m; w_data = d; addr = a;
    @(posedge clk); #1;
    r_en = 1'b0; w_en = 1'b0;
  endtask

  // Full RAM read of the word at a; checks strobes cycle by cycle and the result.
  task automatic ram_read(input string nm, input logic [31:0] a, input logic [31:0] exp_word);
    logic [3:0] ctl, exp_ctl;
    issue(1'b1, 1'b0, 4'b0, 32'h0, a);
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      ctl = {ram_en, ram_we, busy, done};
      exp_ctl = (c <= 4) ? 4'b1010 : 4'b0001;
      checks++;
      if (ctl !== exp_ctl) begin
        failures++;
        $display("FAIL %s_ctl cyc%0d got=%b exp=%b", nm, c, ctl, exp_ctl);
      end
      if (c <= 4) begin
        checks++;
        if (ram_addr !== {a[16:2], 2'(c - 1)}) begin
          failures++;
          $display("FAIL %s_addr cyc%0d got=%h exp=%h", nm, c, ram_addr, {a[16:2], 2'(c - 1)});
        end
      end else begin
        checks++;
        if (r_data !== exp_word) begin
          failures++;
          $display("FAIL %s_data got=%h exp=%h", nm, r_data, exp_word);
        end
      end
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL %s_done_pulse got=%b exp=0", nm, done);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; r_en = 0; w_en = 0; w_mask = 0; w_data = 0; addr = 0;
    repeat (2) @(negedge clk);
    checks++;
    if ({r_data, busy, done, ram_en, ram_we, ram_addr, ram_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {r_data, busy, done, ram_en, ram_we, ram_addr, ram_wdata});
    end
    rst = 1'b0;
  endtask

  task automatic test_read;
    poke(12'h100, 8'h78); poke(12'h101, 8'h56); poke(12'h102, 8'h34); poke(12'h103, 8'h12);
    ram_read("read", 32'h102, 32'h12345678);
  endtask

  task automatic test_write_single;
    poke(12'h204, 8'h11); poke(12'h205, 8'h22); poke(12'h206, 8'h33); poke(12'h207, 8'h44);
    issue(1'b0, 1'b1, 4'b0100, 32'hABABABAB, 32'h206);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done, ram_addr, ram_wdata} !== {4'b1110, 17'h206, 8'hAB}) begin
      failures++;
      $display("FAIL wr1_issue got=%b/%h/%h exp=1110/206/ab",
               {ram_en, ram_we, busy, done}, ram_addr, ram_wdata);
    end
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL wr1_done got=%b exp=0001", {ram_en, ram_we, busy, done});
    end
    checks++;
    if ({ram[12'h207], ram[12'h206], ram[12'h205], ram[12'h204]} !== 32'h44AB2211) begin
      failures++;
      $display("FAIL wr1_ram got=%h exp=44ab2211",
               {ram[12'h207], ram[12'h206], ram[12'h205], ram[12'h204]});
    end
  endtask

  task automatic test_write_full;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
    issue(1'b0, 1'b1, 4'b1111, 32'hDEADBEEF, 32'h40);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, ram_we, busy, done, ram_addr, ram_wdata} !==
          {4'b1110, 17'h40 + 17'(c - 1), exp_b[c - 1]}) begin
        failures++;
        $display("FAIL wr4_issue cyc%0d got=%b/%h/%h exp=1110/%h/%h", c,
                 {ram_en, ram_we, busy, done}, ram_addr, ram_wdata, 17'h40 + 17'(c - 1), exp_b[c - 1]);
      end
    end
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL wr4_done got=%b exp=0001", {ram_en, ram_we, busy, done});
    end
    ram_read("wr4_readback", 32'h40, 32'hDEADBEEF);
  endtask

  task automatic test_both_enables;
    poke(12'h82, 8'h5C);
    issue(1'b1, 1'b1, 4'b0011, 32'hCAFEF00D, 32'h80);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done, ram_addr, ram_wdata} !== {4'b1110, 17'h80, 8'h0D}) begin
      failures++;
      $display("FAIL both_c1 got=%b/%h/%h exp=1110/80/0d", {ram_en, ram_we, busy, done}, ram_addr, ram_wdata);
    end
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done, ram_addr, ram_wdata} !== {4'b1110, 17'h81, 8'hF0}) begin
      failures++;
      $display("FAIL both_c2 got=%b/%h/%h exp=1110/81/f0", {ram_en, ram_we, busy, done}, ram_addr, ram_wdata);
    end
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL both_done got=%b exp=0001", {ram_en, ram_we, busy, done});
    end
    checks++;
    if ({ram[12'h82], ram[12'h81], ram[12'h80]} !== 24'h5CF00D) begin
      failures++;
      $display("FAIL both_ram got=%h exp=5cf00d", {ram[12'h82], ram[12'h81], ram[12'h80]});
    end
    checks++;
    if (r_data !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL both_rdata_hold got=%h exp=deadbeef", r_data);
    end
  endtask

  task automatic test_mask_zero;
    issue(1'b0, 1'b1, 4'b0000, 32'h12345678, 32'h84);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL mask0_done got=%b exp=0001", {ram_en, ram_we, busy, done});
    end
    @(negedge clk);
    checks++;
    if ({ram_en, busy, done} !== 3'b000) begin
      failures++;
      $display("FAIL mask0_idle got=%b exp=000", {ram_en, busy, done});
    end
  endtask

  task automatic test_reset_mid_read;
    issue(1'b1, 1'b0, 4'b0, 32'h0, 32'h100);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({ram_en, busy, done, r_data} !== 35'h0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%b/%h exp=000/0", {ram_en, busy, done}, r_data);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({ram_en, busy, done} !== 3'b000) begin
        failures++;
        $display("FAIL rstmid_quiet cyc%0d got=%b exp=000", c, {ram_en, busy, done});
      end
    end
  endtask

  task automatic test_rbuf;
    ram_read("rbuf_first", 32'h40, 32'hDEADBEEF);
`ifdef DMEM_CTRL_RBUF_EN
    issue(1'b1, 1'b0, 4'b0, 32'h0, 32'h40);
    @(negedge clk);
    checks++;
    if ({ram_en, busy, done, r_data} !== {3'b001, 32'hDEADBEEF}) begin
      failures++;
      $display("FAIL rbuf_hit got=%b/%h exp=001/deadbeef", {ram_en, busy, done}, r_data);
    end
    issue(1'b0, 1'b1, 4'b0010, 32'h00007700, 32'h41);
    repeat (2) @(negedge clk);
    ram_read("rbuf_after_sb", 32'h40, 32'hDEAD77EF);
`else
    ram_read("nobuf_second", 32'h40, 32'hDEADBEEF);
`endif
  endtask

  initial begin
    test_reset;
    test_read;
    test_write_single;
    test_write_full;
    test_both_enables;
    test_mask_zero;
    test_reset_mid_read;
    test_rbuf;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Responder end of the MEM-stage data-memory request interface: accepts word-level read/write requests and executes them as byte accesses on a byte-wide synchronous RAM.
- Drives the `mem_busy` / `mem_done` handshake back to the MEM stage and returns the assembled read word.
- Sits between the MEM stage and the data RAM (or the RAM-side arbiter).

Parameters:
- ADDR_W, 17, byte-address width presented to the RAM.
- RD_LAT, 1, RAM read latency in cycles from `ram_en_o` (with `ram_we_o` = 0) to valid `ram_rdata_i`; legal range 1..3.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, reset asynchronous and active-high
- mem_r_enable_i  in  1  read request (level)
- mem_w_enable_i  in  1  write request (level)
- mem_w_mask_i  in  4  byte-lane write mask; bit k = lane k
- mem_w_data_i  in  32  write data; lane k = bits [8k+7:8k]
- mem_addr_i  in  32  request address; bits [1:0] ignored, word-aligned
- mem_r_data_o  out  32  assembled read word
- mem_busy_o  out  1  request in progress
- mem_done_o  out  1  one-cycle completion pulse
- ram_en_o  out  1  RAM access strobe
- ram_we_o  out  1  RAM write strobe (valid with `ram_en_o`)
- ram_addr_o  out  ADDR_W  RAM byte address
- ram_wdata_o  out  8  RAM write byte
- ram_rdata_i  in  8  RAM read byte

Behaviour:
- Reset (async, immediate), all outputs 0: `mem_r_data_o`, `mem_busy_o`, `mem_done_o`, `ram_en_o`, `ram_we_o`, `ram_addr_o`, `ram_wdata_o`. State returns to IDLE. Any in-flight request is abandoned with no `mem_done_o`; RAM strobes drop in the reset cycle.
- States: IDLE, RD, WR, DONE.
- IDLE, acceptance (cycle 0):
  - Request sampled at the clock edge.
  - If `mem_w_enable_i` = 1, latch addr/mask/data and go to WR.
  - Otherwise, if `mem_r_enable_i` = 1, latch addr and go to RD.
  - Write wins when both are high.
  - Request inputs are ignored in every state other than IDLE.
- `mem_busy_o` = 1 in RD and WR, 0 in IDLE and DONE.
- RD:
  - Cycles 1..4 issue lane k = 0,1,2,3 in order: `ram_en_o` = 1, `ram_we_o` = 0, `ram_addr_o` = {addr[ADDR_W-1:2], k[1:0]}.
  - Byte for lane k is captured from `ram_rdata_i` at the end of cycle 1+k+RD_LAT-1 into bits [8k+7:8k] of an internal word.
  - After the lane-3 capture (end of cycle 4+RD_LAT-1), the word is copied to `mem_r_data_o` and the state goes to DONE.
  - Total read latency: `mem_done_o` high in cycle 4+RD_LAT.
- WR:
  - Issue only lanes whose mask bit is set, ascending, one per cycle starting at cycle 1: `ram_en_o` = 1, `ram_we_o` = 1, `ram_addr_o` as above, `ram_wdata_o` = lane byte.
  - N set bits means DONE in cycle N+1.
  - Mask 0000: no RAM access; DONE in cycle 1.
- DONE: `mem_done_o` = 1 for exactly one cycle, then IDLE. A new request is accepted no earlier than the cycle after DONE.
- `mem_r_data_o` holds its value until the next read completes; it is valid during the read's DONE cycle, which the MEM stage consumes combinationally. Writes never change it.
- Address bits above ADDR_W are ignored; no range checking.

Optional Feature:
- Macro `DMEM_CTRL_RBUF_EN`: one-word read buffer (tag = addr[ADDR_W-1:2] plus a valid bit).
- Defined:
  - A read whose word tag matches a valid buffer goes IDLE -> DONE: `mem_done_o` in cycle 1, no RAM access, `mem_r_data_o` = buffered word.
  - Every completed RAM read fills the buffer.
  - Any accepted write to the same tag clears valid, including a mask-0000 write.
  - Reset clears valid.
- Undefined: every read goes through RD; no buffer state exists.

Test Plan:
- Reset mid-read: reset asserted in cycle 2 of a read -> `ram_en_o`/`mem_busy_o` drop in the same cycle, no `mem_done_o`, `mem_r_data_o` = 0.
- Read, RAM bytes 0x100..0x103 = 0x78,0x56,0x34,0x12, `mem_addr_i` = 0x102, RD_LAT = 1 -> lane addresses 0x100..0x103 in cycles 1..4, `mem_done_o` in cycle 5, `mem_r_data_o` = 0x12345678.
- Write, mask 0100, data 0xABABABAB, addr 0x206 -> single RAM write at 0x206 of 0xAB in cycle 1, `mem_done_o` in cycle 2, other bytes unchanged.
- Write, mask 1111, data 0xDEADBEEF, addr 0x40 -> writes EF,BE,AD,DE to 0x40..0x43 in cycles 1..4, done in cycle 5; a following read of 0x40 returns 0xDEADBEEF.
- Both enables high with mask 0011 -> write performed, no read strobes; mask 0000 write -> done in cycle 1 with no `ram_en_o`.
- With `DMEM_CTRL_RBUF_EN`: read 0x40 twice -> second read gives done in cycle 1 with no `ram_en_o`; an intervening SB to 0x41 forces the third read through the RAM.
